// File: rtl/test_checker_pkg.sv
// Shared types and width helpers for the test_checker result collector.
package test_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_t;

  // Index/counter width that stays at least one bit wide for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/test_checker_lane_cmp.sv
// Per-lane expected/actual compare with a lowest-index priority pick of the
// first mismatching lane and its data.
module test_checker_lane_cmp
  import test_checker_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2,
  parameter int CH_W   = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]        valid,
  input  logic [N_CH*DATA_W-1:0] expected,
  input  logic [N_CH*DATA_W-1:0] actual,
  output logic                   any_mismatch,
  output logic [CH_W-1:0]        mismatch_ch,
  output logic [DATA_W-1:0]      sel_exp,
  output logic [DATA_W-1:0]      sel_act
);

  logic [N_CH-1:0] lane_mis;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign lane_mis[gi] = valid[gi] &&
        (expected[gi*DATA_W +: DATA_W] != actual[gi*DATA_W +: DATA_W]);
    end
  endgenerate

  assign any_mismatch = |lane_mis;

  // Walk from the top lane down so the lowest mismatching lane is the last writer.
  always_comb begin
    mismatch_ch = '0;
    sel_exp     = expected[DATA_W-1:0];
    sel_act     = actual[DATA_W-1:0];
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (lane_mis[i]) begin
        mismatch_ch = CH_W'(i);
        sel_exp     = expected[i*DATA_W +: DATA_W];
        sel_act     = actual[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/test_checker.sv
// Self-checking result collector: counts compare vectors against a budget,
// captures the first failure and reports pass/fail/timeout status.
module test_checker
  import test_checker_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int N_CH         = 2,
  parameter int N_TESTS      = 1000,
  parameter int TIMEOUT      = 4096,
  parameter int STOP_ON_FAIL = 1,
  localparam int CNT_W       = clog2_min1(N_TESTS + 1),
  localparam int CH_W        = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH-1:0]        valid,
  input  logic [N_CH*DATA_W-1:0] expected,
  input  logic [N_CH*DATA_W-1:0] actual,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out,
  output logic [CNT_W-1:0]       test_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [CNT_W-1:0]       ff_idx,
  output logic [CH_W-1:0]        ff_ch,
  output logic [DATA_W-1:0]      ff_exp,
  output logic [DATA_W-1:0]      ff_act
);

  localparam int IDLE_W = clog2_min1(TIMEOUT + 1);

  state_t            state_reg;
  logic [IDLE_W-1:0] idle_reg;

  logic              any_mismatch;
  logic [CH_W-1:0]   mismatch_ch;
  logic [DATA_W-1:0] sel_exp;
  logic [DATA_W-1:0] sel_act;
  logic [CNT_W-1:0]  test_cnt_next;
  logic [IDLE_W-1:0] idle_next;

  test_checker_lane_cmp #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .CH_W   (CH_W)
  ) u_lane_cmp (
    .valid        (valid),
    .expected     (expected),
    .actual       (actual),
    .any_mismatch (any_mismatch),
    .mismatch_ch  (mismatch_ch),
    .sel_exp      (sel_exp),
    .sel_act      (sel_act)
  );

  assign test_cnt_next = test_cnt + CNT_W'(1);
  assign idle_next     = idle_reg + IDLE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idle_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      test_cnt  <= '0;
      fail_cnt  <= '0;
      ff_idx    <= '0;
      ff_ch     <= '0;
      ff_exp    <= '0;
      ff_act    <= '0;
    end else if (start) begin
      state_reg <= RUN;
      idle_reg  <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      test_cnt  <= '0;
      fail_cnt  <= '0;
      ff_idx    <= '0;
      ff_ch     <= '0;
      ff_exp    <= '0;
      ff_act    <= '0;
    end else if (state_reg == RUN) begin
      if (|valid) begin
        test_cnt <= test_cnt_next;
        idle_reg <= '0;
        if (any_mismatch) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
          if (fail_cnt == '0) begin
            ff_idx <= test_cnt;
            ff_ch  <= mismatch_ch;
            ff_exp <= sel_exp;
            ff_act <= sel_act;
          end
        end
        // A mismatch on the final vector still ends in FAIL, with the vector counted.
        if (any_mismatch && (STOP_ON_FAIL != 0)) begin
          state_reg <= FAIL;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else if (test_cnt_next == CNT_W'(N_TESTS)) begin
          busy <= 1'b0;
          done <= 1'b1;
          if (any_mismatch || (fail_cnt != '0)) begin
            state_reg <= FAIL;
          end else begin
            state_reg <= DONE;
            pass      <= 1'b1;
          end
        end
      end else if (TIMEOUT != 0) begin
        idle_reg <= idle_next;
        if (idle_next == IDLE_W'(TIMEOUT)) begin
          state_reg <= FAIL;
          busy      <= 1'b0;
          done      <= 1'b1;
          timed_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_test_checker.sv
// Bench for test_checker: directed table, continue-on-fail sequence and random
// stimulus, all checked against a cycle-level behavioural model.
module tb_test_checker;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int NT = 4;
  localparam int TO = 8;
  localparam int CW = 3;
  localparam int HW = 1;
  localparam int OW = 4 + 3*CW + HW + 2*DW;

  localparam logic [15:0] EQ = 16'h3CA5;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [NC-1:0]   valid;
  logic [NC*DW-1:0] expected, actual;

  logic s_busy, s_done, s_pass, s_to;
  logic [CW-1:0] s_test, s_fail, s_idx;
  logic [HW-1:0] s_ch;
  logic [DW-1:0] s_exp, s_act;
  logic c_busy, c_done, c_pass, c_to;
  logic [CW-1:0] c_test, c_fail, c_idx;
  logic [HW-1:0] c_ch;
  logic [DW-1:0] c_exp, c_act;

  always #5 clk = ~clk;

  test_checker #(.DATA_W(DW), .N_CH(NC), .N_TESTS(NT), .TIMEOUT(TO), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .expected(expected), .actual(actual),
    .busy(s_busy), .done(s_done), .pass(s_pass), .timed_out(s_to), .test_cnt(s_test),
    .fail_cnt(s_fail), .ff_idx(s_idx), .ff_ch(s_ch), .ff_exp(s_exp), .ff_act(s_act));

  test_checker #(.DATA_W(DW), .N_CH(NC), .N_TESTS(NT), .TIMEOUT(TO), .STOP_ON_FAIL(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .expected(expected), .actual(actual),
    .busy(c_busy), .done(c_done), .pass(c_pass), .timed_out(c_to), .test_cnt(c_test),
    .fail_cnt(c_fail), .ff_idx(c_idx), .ff_ch(c_ch), .ff_exp(c_exp), .ff_act(c_act));

  logic [OW-1:0] s_obs, c_obs;
  assign s_obs = {s_busy, s_done, s_pass, s_to, s_test, s_fail, s_idx, s_ch, s_exp, s_act};
  assign c_obs = {c_busy, c_done, c_pass, c_to, c_test, c_fail, c_idx, c_ch, c_exp, c_act};

  // Behavioural model: a run is a phase plus a few tallies.
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_FAIL = 3;
  typedef struct {
    int phase; int tests; int fails; int idle; int timed;
    int ff_idx; int ff_ch; int ff_exp; int ff_act;
  } mdl_t;

  mdl_t ms, mc;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic model_step(inout mdl_t m, input bit stop);
    int bad;
    bad = -1;
    if (rst) begin
      m = '{default: 0};
    end else if (start) begin
      m = '{default: 0};
      m.phase = P_RUN;
    end else if (m.phase == P_RUN) begin
      if (valid != 0) begin
        for (int i = 0; i < NC; i++) begin
          if (valid[i] && expected[i*DW +: DW] != actual[i*DW +: DW]) begin
            bad = i;
            break;
          end
        end
        if (bad >= 0 && m.fails == 0) begin
          m.ff_idx = m.tests;
          m.ff_ch  = bad;
          m.ff_exp = int'(expected[bad*DW +: DW]);
          m.ff_act = int'(actual[bad*DW +: DW]);
        end
        m.tests++;
        m.idle = 0;
        if (bad >= 0) m.fails++;
        if (bad >= 0 && stop) m.phase = P_FAIL;
        else if (m.tests == NT) m.phase = (m.fails > 0) ? P_FAIL : P_DONE;
      end else begin
        m.idle++;
        if (m.idle == TO) begin
          m.phase = P_FAIL;
          m.timed = 1;
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] expect_of(input mdl_t m);
    return {m.phase == P_RUN, m.phase >= P_DONE, m.phase == P_DONE && m.fails == 0,
            m.timed != 0, CW'(m.tests), CW'(m.fails), CW'(m.ff_idx), HW'(m.ff_ch),
            DW'(m.ff_exp), DW'(m.ff_act)};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h required %h", name, got, want);
    else n_pass++;
  endtask

  task automatic tick();
    model_step(ms, 1'b1);
    model_step(mc, 1'b0);
    @(posedge clk);
    #1;
    check("model_stop", s_obs, expect_of(ms));
    check("model_cont", c_obs, expect_of(mc));
  endtask

  function automatic logic [OW-1:0] w(input bit b, input bit d, input bit p, input bit t,
      input int tc, input int fc, input int ix, input int ch, input int fe, input int fa);
    return {b, d, p, t, CW'(tc), CW'(fc), CW'(ix), HW'(ch), DW'(fe), DW'(fa)};
  endfunction

  typedef struct {
    bit rst; bit start; logic [1:0] valid; logic [15:0] exp; logic [15:0] act;
    logic [OW-1:0] want;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit s, input logic [1:0] v, input logic [15:0] e,
                     input logic [15:0] a, input logic [OW-1:0] want);
    vec_t x;
    x.rst = r; x.start = s; x.valid = v; x.exp = e; x.act = a; x.want = want;
    tbl.push_back(x);
  endtask

  initial begin
    ms = '{default: 0};
    mc = '{default: 0};
    rst = 1'b1; start = 1'b0; valid = '0; expected = '0; actual = '0;
    tick();
    tick();
    check("reset_stop", s_obs, '0);
    check("reset_cont", c_obs, '0);
    rst = 1'b0;

    // Expectations below are for the stop-on-fail instance.
    add(0, 1, 2'b00, EQ, EQ, w(1,0,0,0, 0,0,0,0,0,0));           // clean run
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 1,0,0,0,0,0));
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 2,0,0,0,0,0));
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 3,0,0,0,0,0));
    add(0, 0, 2'b11, EQ, EQ, w(0,1,1,0, 4,0,0,0,0,0));
    add(0, 1, 2'b00, EQ, EQ, w(1,0,0,0, 0,0,0,0,0,0));           // stop on fail
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 1,0,0,0,0,0));
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 2,0,0,0,0,0));
    add(0, 0, 2'b11, 16'h10A5, 16'h11A5, w(0,1,0,0, 3,1,2,1,8'h10,8'h11));
    add(0, 0, 2'b11, EQ, EQ, w(0,1,0,0, 3,1,2,1,8'h10,8'h11));
    add(0, 1, 2'b00, EQ, EQ, w(1,0,0,0, 0,0,0,0,0,0));           // masking
    add(0, 0, 2'b01, 16'h10A5, 16'h11A5, w(1,0,0,0, 1,0,0,0,0,0));
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 2,0,0,0,0,0));
    add(0, 1, 2'b11, EQ, EQ, w(1,0,0,0, 0,0,0,0,0,0));           // restart mid-run
    add(0, 0, 2'b11, EQ, EQ, w(1,0,0,0, 1,0,0,0,0,0));
    for (int k = 0; k < TO - 1; k++) add(0, 0, 2'b00, EQ, EQ, w(1,0,0,0, 1,0,0,0,0,0));
    add(0, 0, 2'b00, EQ, EQ, w(0,1,0,1, 1,0,0,0,0,0));           // timeout
    add(1, 1, 2'b11, EQ, EQ, '0);                                // rst beats start
    add(0, 0, 2'b11, EQ, EQ, '0);                                // valid in IDLE

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; start = tbl[k].start; valid = tbl[k].valid;
      expected = tbl[k].exp; actual = tbl[k].act;
      tick();
      check($sformatf("table_%0d", k), s_obs, tbl[k].want);
    end
    rst = 1'b0; start = 1'b0; valid = '0;

    // Continue-on-fail sequence.
    start = 1'b1; tick(); start = 1'b0;
    valid = 2'b11; expected = 16'h0501; actual = 16'h0602; tick();
    expected = EQ; actual = EQ; tick(); tick();
    expected = 16'h10A5; actual = 16'h11A5; tick();
    valid = '0;
    check("cont_done",     OW'(c_done),  OW'(1));
    check("cont_pass",     OW'(c_pass),  OW'(0));
    check("cont_test_cnt", OW'(c_test),  OW'(4));
    check("cont_fail_cnt", OW'(c_fail),  OW'(2));
    check("cont_ff_idx",   OW'(c_idx),   OW'(0));
    check("cont_ff_ch",    OW'(c_ch),    OW'(0));
    check("cont_ff_exp",   OW'(c_exp),   OW'(8'h01));
    check("cont_ff_act",   OW'(c_act),   OW'(8'h02));
    check("stop_at_v0",    s_obs,        w(0,1,0,0, 1,1,0,0,8'h01,8'h02));

    // Random stimulus, alternating busy and idle-heavy stretches.
    for (int blk = 0; blk < 30; blk++) begin
      bit quiet;
      quiet = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 25; k++) begin
        logic [15:0] e, flip;
        rst   = ($urandom_range(0, 99) == 0);
        start = ($urandom_range(0, 29) == 0);
        if (quiet) valid = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        else       valid = 2'($urandom_range(0, 3));
        e = 16'($urandom);
        flip = '0;
        for (int l = 0; l < NC; l++)
          if ($urandom_range(0, 7) == 0) flip[l*DW +: DW] = DW'(1) << $urandom_range(0, DW - 1);
        expected = e;
        actual   = e ^ flip;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
